// File: rtl/mini_core_pipe.sv
// mini_core_pipe
//   Three-stage in-order core: IF -> RD -> EX/WB. Instructions are {op, src1, src2, dst}:
//   op 00 add, 01 sub, 10 multiply (low DATA_W bits), 11 halt. Operands live in an
//   internal data memory. Programs and data are preloaded while load_en=1.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset (control state only; memories keep contents)
//   load_en      in   1 = load mode (pipeline cleared, memories writable), 0 = run
//   imem_we      in   instruction write strobe, writes imem[write pointer] and bumps the pointer
//   imem_wdata   in   instruction to write
//   dmem_we      in   data preload strobe
//   dmem_waddr   in   data preload address
//   dmem_wdata   in   data preload value
//   dbg_addr     in   debug read address
//   dbg_data     out  combinational dmem[dbg_addr]
//   pc           out  address of the instruction being fetched
//   stall        out  EX holds an unfinished multiply
//   retired      out  number of instructions written back (wraps at 2^16)
//   halted       out  sticky halt flag, cleared only by rst
module mini_core_pipe #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int IMEM_AW = 5,
    parameter int MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_en,
    input  logic                    imem_we,
    input  logic [2+3*ADDR_W-1:0]   imem_wdata,
    input  logic                    dmem_we,
    input  logic [ADDR_W-1:0]       dmem_waddr,
    input  logic [DATA_W-1:0]       dmem_wdata,
    input  logic [ADDR_W-1:0]       dbg_addr,
    output logic [DATA_W-1:0]       dbg_data,
    output logic [IMEM_AW-1:0]      pc,
    output logic                    stall,
    output logic [15:0]             retired,
    output logic                    halted
);

    localparam int INST_W = 2 + 3*ADDR_W;
    localparam int CNT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    // Multiply result truncated to the data width (arithmetic is modulo 2^DATA_W).
    function automatic logic [DATA_W-1:0] mul_lo(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return p[DATA_W-1:0];
    endfunction

    logic [INST_W-1:0] imem [2**IMEM_AW];
    logic [DATA_W-1:0] dmem [2**ADDR_W];

    // Control state
    logic [IMEM_AW-1:0] pc_q, wptr_q;
    logic               vld_p0_q, vld_p1_q, halted_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        retired_q;

    // Datapath state
    logic [INST_W-1:0]  inst_p0_q;
    logic [1:0]         op_p1_q;
    logic [ADDR_W-1:0]  dst_p1_q;
    logic [DATA_W-1:0]  a_p1_q, b_p1_q;
    logic [DATA_W-1:0]  a_p1_d, b_p1_d;

    logic               run, halt_ex, stall_w, wb, adv;
    logic [DATA_W-1:0]  ex_res;
    logic [1:0]         op_p0;
    logic [ADDR_W-1:0]  s1_p0, s2_p0, dst_p0;

    assign op_p0  = inst_p0_q[INST_W-1 -: 2];
    assign s1_p0  = inst_p0_q[3*ADDR_W-1 -: ADDR_W];
    assign s2_p0  = inst_p0_q[2*ADDR_W-1 -: ADDR_W];
    assign dst_p0 = inst_p0_q[ADDR_W-1:0];

    assign run     = !load_en && !halted_q;
    assign halt_ex = vld_p1_q && (op_p1_q == OP_HALT);
    // A multiply holds EX until its counter reaches the last cycle.
    assign stall_w = vld_p1_q && (op_p1_q == OP_MUL) && (cnt_q != MUL_LAST);
    assign wb      = run && vld_p1_q && !halt_ex && !stall_w;
    assign adv     = run && !halt_ex && !stall_w;

    always_comb begin
        ex_res = '0;
        case (op_p1_q)
            OP_ADD:  ex_res = a_p1_q + b_p1_q;
            OP_SUB:  ex_res = a_p1_q - b_p1_q;
            OP_MUL:  ex_res = mul_lo(a_p1_q, b_p1_q);
            default: ex_res = '0;
        endcase
    end

    // Forward the EX result when it is written back this cycle to a register RD reads.
    always_comb begin
        a_p1_d = dmem[s1_p0];
        b_p1_d = dmem[s2_p0];
        if (wb && (dst_p1_q == s1_p0)) a_p1_d = ex_res;
        if (wb && (dst_p1_q == s2_p0)) b_p1_d = ex_res;
    end

    // ---- control: pc, valids, multiply counter, halt, retire count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= '0;
            wptr_q    <= '0;
            vld_p0_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
            retired_q <= '0;
        end else begin
            if (load_en && imem_we) wptr_q <= wptr_q + 1'b1;
            if (load_en) begin
                pc_q     <= '0;
                vld_p0_q <= 1'b0;
                vld_p1_q <= 1'b0;
                cnt_q    <= '0;
            end else if (!halted_q) begin
                if (halt_ex) begin
                    halted_q <= 1'b1;
                    vld_p0_q <= 1'b0;
                    vld_p1_q <= 1'b0;
                end else if (stall_w) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q    <= '0;
                    pc_q     <= pc_q + 1'b1;
                    vld_p0_q <= 1'b1;
                    vld_p1_q <= vld_p0_q;
                end
            end
            if (wb) retired_q <= retired_q + 1'b1;
        end
    end

    // ---- IF -> RD boundary (p0) and RD -> EX boundary (p1)
    always_ff @(posedge clk) begin
        if (adv) begin
            inst_p0_q <= imem[pc_q];
            op_p1_q   <= op_p0;
            dst_p1_q  <= dst_p0;
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
        end
    end

    // ---- memories: load-mode writes and EX writeback never coincide
    always_ff @(posedge clk) begin
        if (load_en && imem_we) imem[wptr_q] <= imem_wdata;
        if (load_en && dmem_we) dmem[dmem_waddr] <= dmem_wdata;
        else if (wb)            dmem[dst_p1_q] <= ex_res;
    end

    assign dbg_data = dmem[dbg_addr];
    assign pc       = pc_q;
    assign stall    = stall_w;
    assign retired  = retired_q;
    assign halted   = halted_q;

endmodule
